count_wrap_monitor: RTL and testbench

//  Downstream observer of the 4-bit up/down counter output.

---
 rtl/count_wrap_monitor.sv | 159 +++++++++++++++
 tb/tb_count_wrap_monitor.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/count_wrap_monitor.sv
// Observer for a 4-bit up/down counter: classifies each transition, tracks a signed
// net-wrap position and queues timestamped wrap events for a valid/ready consumer.
module count_wrap_monitor #(
   parameter int WRAP_W     = 8,
   parameter int TS_W       = 12,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [3:0]        count_in,
   input  logic              cnt_clr,
   input  logic              err_clr,
   output logic              evt_valid,
   input  logic              evt_ready,
   output logic              evt_dir,
   output logic [TS_W-1:0]   evt_ts,
   output logic [WRAP_W-1:0] wrap_pos,
   output logic              err_jump,
   output logic              err_drop,
   output logic              err_ovf
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [PTR_W:0] OCC_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic signed [WRAP_W-1:0] WRAP_MAX = {1'b0, {(WRAP_W-1){1'b1}}};
   localparam logic signed [WRAP_W-1:0] WRAP_MIN = {1'b1, {(WRAP_W-1){1'b0}}};
   localparam logic signed [WRAP_W-1:0] WRAP_ONE = WRAP_W'(1);

   function automatic logic signed [WRAP_W-1:0] wrap_step(
      input logic signed [WRAP_W-1:0] v,
      input logic                     down
   );
      return down ? (v - WRAP_ONE) : (v + WRAP_ONE);
   endfunction

   function automatic logic wrap_ovf(
      input logic signed [WRAP_W-1:0] v,
      input logic                     down
   );
      return down ? (v == WRAP_MIN) : (v == WRAP_MAX);
   endfunction

   logic [3:0]               prev;
   logic                     clr_q;
   logic                     primed;
   logic [TS_W-1:0]          ts;
   logic signed [WRAP_W-1:0] wrap_q;

   logic signed [4:0] diff;
   logic              is_up;
   logic              is_down;
   logic              is_jump;
   logic              wrap_evt;

   logic              dir_mem [FIFO_DEPTH];
   logic [TS_W-1:0]   ts_mem  [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W:0]    occ;
   logic              last_dir;
   logic [TS_W-1:0]   last_ts;
   logic              full;
   logic              pop;
   logic              push;
   logic              drop;

   // Classification of (prev -> count_in); a pending clear masks everything
   always_comb begin
      diff    = $signed({1'b0, count_in}) - $signed({1'b0, prev});
      is_up   = 1'b0;
      is_down = 1'b0;
      is_jump = 1'b0;
      if (primed && !clr_q && (count_in != prev)) begin
         if (prev == 4'd15 && count_in == 4'd0)
            is_up = 1'b1;
         else if (prev == 4'd0 && count_in == 4'd15)
            is_down = 1'b1;
         else if (diff != 5'sd1 && diff != -5'sd1)
            is_jump = 1'b1;
      end
   end

   assign wrap_evt  = is_up | is_down;
   assign evt_valid = (occ != '0);
   assign full      = (occ == FULL_CNT);
   assign pop       = evt_valid & evt_ready;
   assign push      = wrap_evt & (~full | pop);
   assign drop      = wrap_evt & full & ~pop;

   // Sample stage: history, clear delay and free-running timestamp
   always_ff @(posedge clk) begin
      if (reset) begin
         prev   <= 4'd0;
         clr_q  <= 1'b0;
         primed <= 1'b0;
         ts     <= '0;
      end else begin
         prev   <= count_in;
         clr_q  <= cnt_clr;
         primed <= 1'b1;
         ts     <= ts + TS_W'(1);
      end
   end

   // Accounting stage: net wraps and sticky flags (a new set beats err_clr)
   always_ff @(posedge clk) begin
      if (reset) begin
         wrap_q   <= '0;
         err_jump <= 1'b0;
         err_drop <= 1'b0;
         err_ovf  <= 1'b0;
      end else begin
         if (wrap_evt)
            wrap_q <= wrap_step(wrap_q, is_down);
         err_jump <= is_jump | (err_jump & ~err_clr);
         err_drop <= drop | (err_drop & ~err_clr);
         err_ovf  <= (wrap_evt & wrap_ovf(wrap_q, is_down)) | (err_ovf & ~err_clr);
      end
   end

   assign wrap_pos = wrap_q;

   // Event FIFO control; the popped head is kept so outputs hold while empty
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         occ      <= '0;
         last_dir <= 1'b0;
         last_ts  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (pop) begin
            rd_ptr   <= rd_ptr + PTR_ONE;
            last_dir <= dir_mem[rd_ptr];
            last_ts  <= ts_mem[rd_ptr];
         end
         unique case ({push, pop})
            2'b10:   occ <= occ + OCC_ONE;
            2'b01:   occ <= occ - OCC_ONE;
            default: occ <= occ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push && !reset) begin
         dir_mem[wr_ptr] <= is_down;
         ts_mem[wr_ptr]  <= ts;
      end
   end

   assign evt_dir = evt_valid ? dir_mem[rd_ptr] : last_dir;
   assign evt_ts  = evt_valid ? ts_mem[rd_ptr]  : last_ts;

endmodule

// File: tb/tb_count_wrap_monitor.sv
// Directed bench for count_wrap_monitor: default instance plus a WRAP_W=4 instance
// driven in parallel for the accumulator overflow case.
module tb_count_wrap_monitor;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, cnt_clr, err_clr, evt_ready;
   logic [3:0]  count_in;

   logic        evt_valid, evt_dir, err_jump, err_drop, err_ovf;
   logic [11:0] evt_ts;
   logic [7:0]  wrap_pos;

   logic        b_evt_valid, b_evt_dir, b_err_jump, b_err_drop, b_err_ovf;
   logic [11:0] b_evt_ts;
   logic [3:0]  b_wrap_pos;

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   logic [3:0]  cur = 4'd0;
   int          q_ts[$];

   count_wrap_monitor dut (
      .clk(clk), .reset(reset), .count_in(count_in), .cnt_clr(cnt_clr),
      .err_clr(err_clr), .evt_valid(evt_valid), .evt_ready(evt_ready),
      .evt_dir(evt_dir), .evt_ts(evt_ts), .wrap_pos(wrap_pos),
      .err_jump(err_jump), .err_drop(err_drop), .err_ovf(err_ovf)
   );

   count_wrap_monitor #(.WRAP_W(4)) dut4 (
      .clk(clk), .reset(reset), .count_in(count_in), .cnt_clr(cnt_clr),
      .err_clr(err_clr), .evt_valid(b_evt_valid), .evt_ready(evt_ready),
      .evt_dir(b_evt_dir), .evt_ts(b_evt_ts), .wrap_pos(b_wrap_pos),
      .err_jump(b_err_jump), .err_drop(b_err_drop), .err_ovf(b_err_ovf)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // cyc tracks the timestamp of the cycle being driven
   task automatic tick(input logic [3:0] c, input logic cl, input logic ec);
      count_in = c;
      cnt_clr  = cl;
      err_clr  = ec;
      cur      = c;
      @(posedge clk);
      #1;
      cyc = reset ? 0 : cyc + 1;
   endtask

   task automatic wrap_up_once();
      logic [3:0] n;
      do begin
         n = cur + 4'd1;
         if (n == 4'd0) q_ts.push_back(cyc);
         tick(n, 1'b0, 1'b0);
      end while (n != 4'd0);
   endtask

   initial begin
      int t;
      reset = 1'b1; count_in = 4'd0; cnt_clr = 1'b0; err_clr = 1'b0; evt_ready = 1'b1;
      tick(4'd0, 1'b0, 1'b0);
      tick(4'd0, 1'b0, 1'b0);
      chk("rst_valid", evt_valid, 0);
      chk("rst_dir", evt_dir, 0);
      chk("rst_ts", evt_ts, 0);
      chk("rst_wrap", wrap_pos, 0);
      chk("rst_errs", {err_jump, err_drop, err_ovf}, 0);

      // Up run
      reset = 1'b0;
      tick(4'd0, 1'b0, 1'b0);
      for (int k = 0; k < 16; k++) tick(4'(k), 1'b0, 1'b0);
      tick(4'd0, 1'b0, 1'b0);
      chk("up_valid", evt_valid, 1);
      chk("up_dir", evt_dir, 0);
      chk("up_ts", evt_ts, 17);
      chk("up_wrap", wrap_pos, 1);
      tick(4'd1, 1'b0, 1'b0);
      chk("up_popped", evt_valid, 0);
      chk("up_ts_hold", evt_ts, 17);
      chk("up_errs", {err_jump, err_drop, err_ovf}, 0);

      // Down run
      for (int k = 2; k < 16; k++) tick(4'(k), 1'b0, 1'b0);
      for (int k = 14; k >= 0; k--) tick(4'(k), 1'b0, 1'b0);
      tick(4'd15, 1'b0, 1'b0);
      chk("dn_valid", evt_valid, 1);
      chk("dn_dir", evt_dir, 1);
      chk("dn_ts", evt_ts, 48);
      chk("dn_wrap", wrap_pos, 0);

      // Clear masks 15 -> 0
      tick(4'd15, 1'b1, 1'b0);
      tick(4'd0, 1'b0, 1'b0);
      chk("clr_valid", evt_valid, 0);
      chk("clr_wrap", wrap_pos, 0);
      chk("clr_jump", err_jump, 0);

      // Illegal jump and err_clr interplay
      tick(4'd1, 1'b0, 1'b0);
      tick(4'd2, 1'b0, 1'b0);
      tick(4'd3, 1'b0, 1'b0);
      chk("step_nojump", err_jump, 0);
      tick(4'd9, 1'b0, 1'b0);
      chk("jump_set", err_jump, 1);
      chk("jump_wrap", wrap_pos, 0);
      tick(4'd9, 1'b0, 1'b1);
      chk("jump_clr", err_jump, 0);
      tick(4'd2, 1'b0, 1'b1);
      chk("jump_beats_clr", err_jump, 1);
      tick(4'd2, 1'b0, 1'b1);
      chk("jump_clr2", err_jump, 0);

      // Backpressure: 5 wraps into a 4-deep FIFO
      q_ts.delete();
      evt_ready = 1'b0;
      for (int w = 0; w < 5; w++) wrap_up_once();
      void'(q_ts.pop_back());
      chk("bp_valid", evt_valid, 1);
      chk("bp_drop", err_drop, 1);
      chk("bp_head_ts", evt_ts, q_ts[0]);
      chk("bp_wrap", wrap_pos, 5);
      tick(4'd0, 1'b0, 1'b1);
      chk("bp_drop_clr", err_drop, 0);
      chk("bp_stable_ts", evt_ts, q_ts[0]);
      for (int k = 1; k < 16; k++) tick(4'(k), 1'b0, 1'b0);
      chk("bp_full_head", evt_ts, q_ts[0]);
      evt_ready = 1'b1;
      t = cyc;
      tick(4'd0, 1'b0, 1'b0);
      void'(q_ts.pop_front());
      q_ts.push_back(t);
      chk("bp_fullpop_nodrop", err_drop, 0);
      chk("bp_wrap6", wrap_pos, 6);
      for (int e = 0; e < 4; e++) begin
         chk("drain_valid", evt_valid, 1);
         chk("drain_dir", evt_dir, 0);
         chk("drain_ts", evt_ts, q_ts[0]);
         void'(q_ts.pop_front());
         tick(4'd0, 1'b0, 1'b0);
      end
      chk("drain_empty", evt_valid, 0);

      // Overflow on the narrow accumulator
      reset = 1'b1;
      tick(4'd0, 1'b0, 1'b0);
      chk("rst2_valid", evt_valid, 0);
      chk("rst2_ts", evt_ts, 0);
      chk("rst2_wrap", wrap_pos, 0);
      chk("rst2_errs", {err_jump, err_drop, err_ovf}, 0);
      reset = 1'b0;
      for (int w = 0; w < 8; w++) wrap_up_once();
      q_ts.delete();
      chk("ovf_wrap4", b_wrap_pos, 4'h8);
      chk("ovf_flag4", b_err_ovf, 1);
      chk("ovf_wrap8", wrap_pos, 8);
      chk("ovf_flag8", err_ovf, 0);

      // Reset mid-stream, then an unclassified first sample
      for (int k = 1; k < 16; k++) tick(4'(k), 1'b0, 1'b0);
      reset = 1'b1;
      tick(4'd15, 1'b0, 1'b0);
      chk("rst3_wrap4", b_wrap_pos, 0);
      chk("rst3_ovf4", b_err_ovf, 0);
      chk("rst3_wrap", wrap_pos, 0);
      chk("rst3_valid", evt_valid, 0);
      reset = 1'b0;
      tick(4'd15, 1'b0, 1'b0);
      chk("prime_valid", evt_valid, 0);
      chk("prime_wrap", wrap_pos, 0);
      chk("prime_jump", err_jump, 0);
      tick(4'd0, 1'b0, 1'b0);
      chk("post_wrap", wrap_pos, 1);
      chk("post_valid", evt_valid, 1);
      chk("post_ts", evt_ts, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
